// File: rtl/fp_match_scheduler.sv
// Purpose: walks every enrolled identity/template, drives the match core and keeps the best identity score.
// Latency: per template ISSUE + core latency + ACCUM; one NEXT cycle per identity, one DONE cycle per pass.
// Backpressure: waits on the core finish pulse (bounded by TIMEOUT_CYC); abort drops the pass at any time.
module fp_match_scheduler #(
  parameter int TPL_PER_ID  = 3,
  parameter int MAX_IDS     = 15,
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 20,
  parameter int FP_WORDS    = 1600,
  parameter int BASE_ADDR   = 13000,
  parameter int SCORE_W     = 16,
  parameter int TIMEOUT_CYC = 1048576,
  localparam int ACC_W      = SCORE_W + 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [ID_W-1:0]    i_db_size,
  input  logic [ACC_W-1:0]   i_threshold,
  input  logic               i_agg_mode,
  input  logic               i_early_exit,
  output logic               o_core_start,
  output logic [ADDR_W-1:0]  o_core_addr,
  input  logic               i_core_finish,
  input  logic [SCORE_W-1:0] i_core_score,
  output logic               o_busy,
  output logic               o_done,
  output logic [ID_W-1:0]    o_match_id,
  output logic [ACC_W-1:0]   o_best_score,
  output logic               o_timeout,
  output logic [2:0]         o_state
);

  localparam int TPL_W  = (TPL_PER_ID > 1) ? $clog2(TPL_PER_ID) : 1;
  localparam int WCNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [TPL_W-1:0]  TPL_LAST  = TPL_W'(TPL_PER_ID - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0]   MAX_ID_V  = ID_W'(MAX_IDS);
  localparam logic [ADDR_W-1:0] BASE_V    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP_V    = ADDR_W'(FP_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACCUM = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Pass configuration, frozen at start so mid-pass input changes are ignored
  logic [ID_W-1:0]    db_size_r;
  logic [ACC_W-1:0]   thr_r;
  logic               mode_r;
  logic               ee_r;

  logic [ID_W-1:0]    id_cnt;
  logic [TPL_W-1:0]   tpl_cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   best;
  logic [ID_W-1:0]    best_id;
  logic [ADDR_W-1:0]  addr;
  logic [WCNT_W-1:0]  wait_cnt;
  logic [SCORE_W-1:0] score_r;

  logic               abort_now;
  logic               start_ok;
  logic [ID_W-1:0]    db_clamp;
  logic               wait_expired;
  logic               tpl_more;
  logic               id_last;
  logic [ACC_W-1:0]   score_ext;
  logic [ACC_W-1:0]   acc_upd;
  logic               acc_gt_best;
  logic [ACC_W-1:0]   best_upd;
  logic [ID_W-1:0]    best_id_upd;
  logic [ACC_W-1:0]   best_fin;
  logic [ID_W-1:0]    best_id_fin;
  logic [ADDR_W-1:0]  addr_d;

  assign abort_now    = (state != S_IDLE) && i_abort;
  assign start_ok     = i_start && !i_abort;
  assign db_clamp     = (i_db_size > MAX_ID_V) ? MAX_ID_V : i_db_size;
  assign wait_expired = (wait_cnt == WCNT_LAST);
  assign tpl_more     = (tpl_cnt < TPL_LAST);
  assign id_last      = (id_cnt == (db_size_r - 1'b1));
  assign score_ext    = ACC_W'(score_r);
  assign acc_gt_best  = (acc > best);
  assign best_upd     = acc_gt_best ? acc : best;
  assign best_id_upd  = acc_gt_best ? (id_cnt + 1'b1) : best_id;

  // Result as seen on entry to DONE: an empty database leaves nothing to report
  assign best_fin     = (state == S_NEXT) ? best_upd : '0;
  assign best_id_fin  = (state == S_NEXT) ? best_id_upd : '0;

  // Per-template aggregation: running max or running sum (4 templates cannot overflow ACC_W)
  always_comb begin
    acc_upd = acc;
    if (mode_r) begin
      acc_upd = acc + score_ext;
    end else if (score_ext > acc) begin
      acc_upd = score_ext;
    end
  end

  // Template address walk: reload on start, step by one template after each call
  always_comb begin
    addr_d = addr;
    if (state == S_IDLE && start_ok) begin
      addr_d = BASE_V;
    end else if (state == S_ACCUM) begin
      addr_d = addr + STEP_V;
    end
  end

  // Next-state logic; abort overrides every non-idle transition
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = (db_clamp == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (i_core_finish || wait_expired) state_nxt = S_ACCUM;
      S_ACCUM: state_nxt = tpl_more ? S_ISSUE : S_NEXT;
      S_NEXT: begin
        if (ee_r && (acc > thr_r))  state_nxt = S_DONE;
        else if (id_last)           state_nxt = S_DONE;
        else                        state_nxt = S_ISSUE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_now) state_nxt = S_IDLE;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Datapath: counters, accumulators, core address and pass results
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      db_size_r    <= '0;
      thr_r        <= '0;
      mode_r       <= 1'b0;
      ee_r         <= 1'b0;
      id_cnt       <= '0;
      tpl_cnt      <= '0;
      acc          <= '0;
      best         <= '0;
      best_id      <= '0;
      addr         <= '0;
      wait_cnt     <= '0;
      score_r      <= '0;
      o_core_addr  <= '0;
      o_match_id   <= '0;
      o_best_score <= '0;
      o_timeout    <= 1'b0;
    end else if (abort_now) begin
      o_match_id <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            db_size_r <= db_clamp;
            thr_r     <= i_threshold;
            mode_r    <= i_agg_mode;
            ee_r      <= i_early_exit;
            id_cnt    <= '0;
            tpl_cnt   <= '0;
            acc       <= '0;
            best      <= '0;
            best_id   <= '0;
            o_timeout <= 1'b0;
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (i_core_finish) begin
            score_r <= i_core_score;
          end else if (wait_expired) begin
            score_r   <= '0;
            o_timeout <= 1'b1;
          end
        end
        S_ACCUM: begin
          acc <= acc_upd;
          if (tpl_more) tpl_cnt <= tpl_cnt + 1'b1;
        end
        S_NEXT: begin
          best    <= best_upd;
          best_id <= best_id_upd;
          id_cnt  <= id_cnt + 1'b1;
          tpl_cnt <= '0;
          acc     <= '0;
        end
        default: ;
      endcase

      addr <= addr_d;
      // Core address only moves on the way into ISSUE, so it is stable for the whole call
      if (state_nxt == S_ISSUE) o_core_addr <= addr_d;
      if (state_nxt == S_DONE) begin
        o_best_score <= best_fin;
        o_match_id   <= (best_fin > thr_r) ? best_id_fin : '0;
      end
    end
  end

  assign o_core_start = (state == S_ISSUE);
  assign o_busy       = (state != S_IDLE);
  assign o_done       = (state == S_DONE);
  assign o_state      = state;

endmodule

// File: tb/tb_fp_match_scheduler.sv
module tb_fp_match_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start, abort_in;
  logic [3:0]  db_size;
  logic [17:0] threshold;
  logic        agg, ee_in;
  logic        o_core_start;
  logic [19:0] o_core_addr;
  logic        rsp_fin, man_fin;
  logic [15:0] rsp_score;
  logic        o_busy, o_done, o_timeout;
  logic [3:0]  o_match_id;
  logic [17:0] o_best_score;
  logic [2:0]  o_state;

  int n_assert = 0;
  int n_fail   = 0;

  // Core model state
  int          score_tab [0:14][0:2];
  int          n_starts;
  logic [19:0] addr_q [$];
  bit          core_silent;
  int          core_lat;

  // Reference results
  int exp_match, exp_best, exp_calls;
  int got_match, got_best, got_to, last_cyc;

  fp_match_scheduler #(.TIMEOUT_CYC(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort_in),
    .i_db_size(db_size), .i_threshold(threshold), .i_agg_mode(agg),
    .i_early_exit(ee_in), .o_core_start(o_core_start), .o_core_addr(o_core_addr),
    .i_core_finish(rsp_fin | man_fin), .i_core_score(rsp_score),
    .o_busy(o_busy), .o_done(o_done), .o_match_id(o_match_id),
    .o_best_score(o_best_score), .o_timeout(o_timeout), .o_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Match core: records each call, answers after core_lat cycles unless silent
  initial begin : core_model
    int k;
    rsp_fin = 1'b0;
    rsp_score = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && o_core_start === 1'b1) begin
        k = n_starts;
        addr_q.push_back(o_core_addr);
        n_starts++;
        if (!core_silent) begin
          repeat (core_lat) @(negedge clk);
          rsp_fin   = 1'b1;
          rsp_score = 16'(score_tab[k/3][k%3]);
          @(negedge clk);
          rsp_fin   = 1'b0;
          rsp_score = '0;
        end
      end
    end
  end

  // Reference: identity score = max or sum of its templates; first strictly-greater identity wins
  task automatic model(input int db, input int thr, input bit mode, input bit ee);
    int s, bid, bst, calls;
    bid = 0; bst = 0; calls = 0;
    if (db > 15) db = 15;
    for (int id = 0; id < db; id++) begin
      s = 0;
      for (int t = 0; t < 3; t++) begin
        int v;
        v = core_silent ? 0 : score_tab[id][t];
        if (mode) s = s + v;
        else if (v > s) s = v;
      end
      calls += 3;
      if (s > bst) begin bst = s; bid = id + 1; end
      if (ee && s > thr) break;
    end
    exp_best  = bst;
    exp_match = (bst > thr) ? bid : 0;
    exp_calls = calls;
  endtask

  task automatic run_pass(input string tag, input int db, input int thr, input bit mode, input bit ee);
    int cyc, dones, addr_err;
    n_starts = 0;
    addr_q.delete();
    model(db, thr, mode, ee);
    @(negedge clk);
    db_size = 4'(db); threshold = 18'(thr); agg = mode; ee_in = ee; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble configuration mid-pass: must have no effect
    db_size = 4'($urandom); threshold = 18'($urandom); agg = 1'($urandom); ee_in = 1'($urandom);
    cyc = 0; dones = 0; last_cyc = -1;
    while (cyc < 20000 && !(dones > 0 && o_busy === 1'b0)) begin
      if (o_done === 1'b1) begin
        dones++;
        if (last_cyc < 0) last_cyc = cyc;
        got_match = int'(o_match_id); got_best = int'(o_best_score); got_to = int'(o_timeout);
      end
      @(negedge clk);
      cyc++;
    end
    repeat (3) begin
      if (o_done === 1'b1) dones++;
      @(negedge clk);
    end
    chk({tag, "_done_pulses"}, dones, 1);
    chk({tag, "_match_id"}, got_match, exp_match);
    chk({tag, "_best_score"}, got_best, exp_best);
    chk({tag, "_core_calls"}, n_starts, exp_calls);
    chk({tag, "_timeout"}, got_to, (core_silent && exp_calls > 0) ? 1 : 0);
    addr_err = 0;
    foreach (addr_q[i]) if (int'(addr_q[i]) != 13000 + 1600 * i) addr_err++;
    chk({tag, "_addr_seq_errors"}, addr_err, 0);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s);
    int n;
    n = 0;
    while (o_state !== s && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_reached_state"}, o_state, s);
  endtask

  task automatic set_id(input int id, input int a, input int b, input int c);
    score_tab[id][0] = a; score_tab[id][1] = b; score_tab[id][2] = c;
  endtask

  initial begin : main
    int prev_best;
    rst_n = 1'b0; start = 1'b0; abort_in = 1'b0; man_fin = 1'b0;
    db_size = '0; threshold = '0; agg = 1'b0; ee_in = 1'b0;
    core_silent = 1'b0; core_lat = 3; n_starts = 0;
    for (int i = 0; i < 15; i++) set_id(i, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_match", o_match_id, 0);
    chk("rst_best", o_best_score, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_state", o_state, 0);
    chk("rst_core_start", o_core_start, 0);
    chk("rst_core_addr", o_core_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Max mode, threshold 1800
    set_id(0, 100, 200, 300); set_id(1, 1900, 50, 1850);
    run_pass("max2", 2, 1800, 1'b0, 1'b0);
    chk("max2_const_id", got_match, 2);
    chk("max2_const_best", got_best, 1900);
    chk("max2_last_addr", o_core_addr, 21000);

    // Sum mode, then strict compare at equality
    run_pass("sum_t3000", 2, 3000, 1'b1, 1'b0);
    chk("sum_const_best", got_best, 3800);
    run_pass("sum_t3800", 2, 3800, 1'b1, 1'b0);
    chk("sum_strict_id", got_match, 0);

    // Early exit on identity 1
    set_id(0, 2000, 0, 0); set_id(1, 2500, 0, 0); set_id(2, 100, 0, 0); set_id(3, 100, 0, 0);
    core_lat = 1;
    run_pass("early", 4, 1800, 1'b0, 1'b1);
    chk("early_const_calls", n_starts, 3);
    chk("early_const_id", got_match, 1);

    // Tie keeps the earlier identity
    set_id(0, 1000, 900, 0); set_id(1, 1500, 0, 10); set_id(2, 0, 1500, 1500);
    core_lat = 2;
    run_pass("tie", 3, 1000, 1'b0, 1'b0);
    chk("tie_const_id", got_match, 2);

    // Empty database
    run_pass("db0", 0, 0, 1'b0, 1'b0);
    chk("db0_latency_ok", (last_cyc >= 0 && last_cyc <= 3), 1);

    // Full database
    for (int i = 0; i < 15; i++) set_id(i, $urandom_range(0, 20) * 200, $urandom_range(0, 20) * 200, $urandom_range(0, 20) * 200);
    run_pass("db15", 15, 2500, 1'b1, 1'b0);
    chk("db15_const_calls", n_starts, 45);
    chk("db15_last_addr", o_core_addr, 13000 + 44 * 1600);

    // Core never answers
    core_silent = 1'b1;
    run_pass("tmo", 2, 0, 1'b0, 1'b0);
    core_silent = 1'b0;
    run_pass("tmo_clear", 2, 0, 1'b0, 1'b0);

    // Randomized passes
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 15; i++) set_id(i, $urandom_range(0, 20) * 200, $urandom_range(0, 20) * 200, $urandom_range(0, 20) * 200);
      core_lat = $urandom_range(1, 6);
      run_pass("rnd", $urandom_range(1, 15), $urandom_range(0, 8000), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Abort in WAIT with a same-cycle finish
    set_id(0, 1000, 900, 0); set_id(1, 1500, 0, 10); set_id(2, 0, 1500, 1500);
    core_lat = 2;
    run_pass("pre_abort", 3, 1000, 1'b0, 1'b0);
    prev_best = int'(o_best_score);
    core_silent = 1'b1;
    @(negedge clk);
    db_size = 4'd3; threshold = 18'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state("abort", 3'd2);
    man_fin = 1'b1; abort_in = 1'b1;
    @(negedge clk);
    man_fin = 1'b0; abort_in = 1'b0;
    chk("abort_state", o_state, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_match", o_match_id, 0);
    chk("abort_best_kept", o_best_score, prev_best);
    begin
      int d;
      d = 0;
      repeat (5) begin if (o_done === 1'b1) d++; @(negedge clk); end
      chk("abort_no_done", d, 0);
    end
    // Start with abort while idle is ignored
    start = 1'b1; abort_in = 1'b1;
    @(negedge clk);
    start = 1'b0; abort_in = 1'b0;
    chk("idle_abort_start_busy", o_busy, 0);
    core_silent = 1'b0;
    run_pass("post_abort", 3, 1000, 1'b0, 1'b0);

    // Asynchronous reset mid-ACCUM
    core_lat = 4;
    @(negedge clk);
    db_size = 4'd5; threshold = 18'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state("arst", 3'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_state", o_state, 0);
    chk("arst_match", o_match_id, 0);
    chk("arst_best", o_best_score, 0);
    chk("arst_core_addr", o_core_addr, 0);
    chk("arst_core_start", o_core_start, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_pass("post_arst", 4, 1200, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
